inst_mem_resp: RTL and testbench

//  Instruction-memory responder: the memory-side end of the core fetch interface.

---
 rtl/inst_mem_resp.sv | 197 +++++++++++++++++++
 tb/tb_inst_mem_resp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_resp
// Purpose  : Instruction-memory responder. This is the memory-side end of the
//            core fetch interface. It accepts a fetch address and returns one
//            32-bit instruction word after WAIT_STATES extra cycles. It flags
//            misaligned and out-of-range fetches. The word-array program store
//            is filled through a separate loader write port.
// Ports    : clk_i               clock, all state on the rising edge
//            rst_i               asynchronous reset, active low
//            req_i / addr_i      fetch request and byte address
//            gnt_o               request accepted when req_i && gnt_o
//            rvalid_o            one-cycle response strobe per accepted request
//            rdata_o / err_o     response word and error flag, held between
//                                responses
//            we_i/waddr_i/wdata_i  loader write port (word index)
//            req_cnt_o/err_cnt_o accepted-request and error-response counters
//                                (only when INST_MEM_PERF_EN is defined)
// Options  : define INST_MEM_PERF_EN to add the performance counters
// Revision : 1.0  initial release
// ============================================================================
module inst_mem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] RESET_INST  = 32'h0000_0013,
    localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic [31:0]   addr_i,
    output logic          gnt_o,
    output logic          rvalid_o,
    output logic [31:0]   rdata_o,
    output logic          err_o,
`ifdef INST_MEM_PERF_EN
    output logic [31:0]   req_cnt_o,
    output logic [31:0]   err_cnt_o,
`endif
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [31:0] c_DEPTH32   = 32'(DEPTH_WORDS);
    localparam logic [29:0] c_BASE_WORD = BASE_ADDR[31:2];
    localparam logic [3:0]  c_WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          gnt_q;
    logic          rvalid_q;
    logic          err_q;
    logic [31:0]   rdata_q;
    logic [31:0]   store_q [DEPTH_WORDS];

    logic          w_accept;
    logic [29:0]   w_word;
    logic          w_dec_err;
    logic [AW-1:0] w_dec_idx;
    logic          w_rsp_err;
    logic [AW-1:0] w_rsp_idx;
    logic [31:0]   w_rsp_data;

    assign w_accept = req_i & gnt_q;

    // Word offset from the base. A below-base address wraps to a large value,
    // but the explicit below-base test flags it anyway.
    assign w_word    = addr_i[31:2] - c_BASE_WORD;
    assign w_dec_err = (|addr_i[1:0]) | (addr_i < BASE_ADDR) | ({2'b00, w_word} >= c_DEPTH32);
    assign w_dec_idx = w_word[AW-1:0];

    // With no wait states the store is read on the accept edge itself, so the
    // live decode is used. Otherwise the decode is captured on accept and
    // used when the wait count expires.
    generate
        if (WAIT_STATES == 0) begin : g_direct
            assign w_rsp_err = w_dec_err;
            assign w_rsp_idx = w_dec_idx;
        end else begin : g_pend
            logic          pend_err_q;
            logic [AW-1:0] pend_idx_q;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    pend_err_q <= 1'b0;
                    pend_idx_q <= '0;
                end else if (w_accept) begin
                    pend_err_q <= w_dec_err;
                    pend_idx_q <= w_dec_idx;
                end
            end

            assign w_rsp_err = pend_err_q;
            assign w_rsp_idx = pend_idx_q;
        end
    endgenerate

    // Errored fetches never touch the store.
    assign w_rsp_data = w_rsp_err ? RESET_INST : store_q[w_rsp_idx];

    // Loader port. The store has no reset. A read and a write of the same word
    // on the same edge returns the old contents, because both are sampled
    // before the update.
    always_ff @(posedge clk_i) begin
        if (we_i && (32'(waddr_i) < c_DEPTH32)) begin
            store_q[waddr_i] <= wdata_i;
        end
    end

    // Fetch FSM. All outputs are registered and are set for the state being
    // entered.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            gnt_q    <= 1'b1;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= RESET_INST;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        if (WAIT_STATES > 0) begin
                            state_q <= S_WAIT;
                            cnt_q   <= c_WAIT_INIT;
                            gnt_q   <= 1'b0;
                        end else begin
                            state_q  <= S_RESP;
                            gnt_q    <= 1'b1;
                            rvalid_q <= 1'b1;
                            err_q    <= w_rsp_err;
                            rdata_q  <= w_rsp_data;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        gnt_q   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= S_RESP;
                        gnt_q    <= 1'b1;
                        rvalid_q <= 1'b1;
                        err_q    <= w_rsp_err;
                        rdata_q  <= w_rsp_data;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= 1'b1;
                end
            endcase
        end
    end

    assign gnt_o    = gnt_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

`ifdef INST_MEM_PERF_EN
    logic [31:0] req_cnt_q;
    logic [31:0] err_cnt_q;

    // Both counters wrap naturally at 32 bits.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_cnt_q <= 32'd0;
            err_cnt_q <= 32'd0;
        end else begin
            if (w_accept) begin
                req_cnt_q <= req_cnt_q + 32'd1;
            end
            if (rvalid_q && err_q) begin
                err_cnt_q <= err_cnt_q + 32'd1;
            end
        end
    end

    assign req_cnt_o = req_cnt_q;
    assign err_cnt_o = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_mem_resp
// Purpose  : Directed self-checking bench for inst_mem_resp. It uses three
//            instances with different configurations:
//              A: WAIT_STATES=1, DEPTH_WORDS=1024, BASE_ADDR=0
//              B: WAIT_STATES=0, DEPTH_WORDS=16,   BASE_ADDR=0
//              C: WAIT_STATES=2, DEPTH_WORDS=16,   BASE_ADDR=32'h1000
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_mem_resp;

    logic clk;
    logic rst_n;

    logic        a_req, a_we, a_gnt, a_rvalid, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [9:0]  a_waddr;
    logic        b_req, b_we, b_gnt, b_rvalid, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_waddr;
    logic        c_req, c_we, c_gnt, c_rvalid, c_err;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [3:0]  c_waddr;
`ifdef INST_MEM_PERF_EN
    logic [31:0] a_rcnt, a_ecnt, b_rcnt, b_ecnt, c_rcnt, c_ecnt;
`endif

    int total = 0;
    int bad   = 0;

    inst_mem_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1), .RESET_INST(32'h13)) u_a (
        .clk_i(clk), .rst_i(rst_n), .req_i(a_req), .addr_i(a_addr), .gnt_o(a_gnt),
        .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err),
`ifdef INST_MEM_PERF_EN
        .req_cnt_o(a_rcnt), .err_cnt_o(a_ecnt),
`endif
        .we_i(a_we), .waddr_i(a_waddr), .wdata_i(a_wdata));

    inst_mem_resp #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .WAIT_STATES(0), .RESET_INST(32'h13)) u_b (
        .clk_i(clk), .rst_i(rst_n), .req_i(b_req), .addr_i(b_addr), .gnt_o(b_gnt),
        .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err),
`ifdef INST_MEM_PERF_EN
        .req_cnt_o(b_rcnt), .err_cnt_o(b_ecnt),
`endif
        .we_i(b_we), .waddr_i(b_waddr), .wdata_i(b_wdata));

    inst_mem_resp #(.DEPTH_WORDS(16), .BASE_ADDR(32'h1000), .WAIT_STATES(2), .RESET_INST(32'h13)) u_c (
        .clk_i(clk), .rst_i(rst_n), .req_i(c_req), .addr_i(c_addr), .gnt_o(c_gnt),
        .rvalid_o(c_rvalid), .rdata_o(c_rdata), .err_o(c_err),
`ifdef INST_MEM_PERF_EN
        .req_cnt_o(c_rcnt), .err_cnt_o(c_ecnt),
`endif
        .we_i(c_we), .waddr_i(c_waddr), .wdata_i(c_wdata));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 0; a_addr = 0; a_we = 0; a_waddr = 0; a_wdata = 0;
        b_req = 0; b_addr = 0; b_we = 0; b_waddr = 0; b_wdata = 0;
        c_req = 0; c_addr = 0; c_we = 0; c_waddr = 0; c_wdata = 0;

        // Reset values
        tick(); tick();
        chk("rst_gnt",    {31'd0, a_gnt},    32'd1);
        chk("rst_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_err",    {31'd0, a_err},    32'd0);
        chk("rst_rdata",  a_rdata,           32'h0000_0013);
        chk("rst_rdata_b", b_rdata,          32'h0000_0013);
        rst_n = 1'b1;
        tick();

        // Load the stores
        a_we = 1; a_waddr = 10'd1; a_wdata = 32'h0050_0093;
        b_we = 1; b_waddr = 4'd0;  b_wdata = 32'h1111_1111;
        c_we = 1; c_waddr = 4'd0;  c_wdata = 32'hC0C0_C0C0;
        tick();
        a_waddr = 10'd2; a_wdata = 32'hAAAA_0002;
        b_waddr = 4'd1;  b_wdata = 32'h2222_2222;
        c_waddr = 4'd1;  c_wdata = 32'hC1C1_C1C1;
        tick();
        b_waddr = 4'd2;  b_wdata = 32'h3333_3333;
        a_we = 0; c_we = 0;
        tick();
        b_we = 0;

        // A: single fetch of word 1, latency 2 cycles
        a_req = 1; a_addr = 32'h4;
        tick();
        a_req = 0;
        chk("a_wait_gnt",    {31'd0, a_gnt},    32'd0);
        chk("a_wait_rvalid", {31'd0, a_rvalid}, 32'd0);
        tick();
        chk("a_rsp_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("a_rsp_rdata",  a_rdata,           32'h0050_0093);
        chk("a_rsp_err",    {31'd0, a_err},    32'd0);
        chk("a_rsp_gnt",    {31'd0, a_gnt},    32'd1);
        tick();
        chk("a_post_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("a_hold_rdata",  a_rdata,           32'h0050_0093);

        // A: misaligned fetch
        a_req = 1; a_addr = 32'h6;
        tick(); a_req = 0; tick();
        chk("a_mis_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("a_mis_err",    {31'd0, a_err},    32'd1);
        chk("a_mis_rdata",  a_rdata,           32'h0000_0013);

        // A: first word past the end
        a_req = 1; a_addr = 32'h1000;
        tick(); a_req = 0; tick();
        chk("a_oor_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("a_oor_err",    {31'd0, a_err},    32'd1);
        chk("a_oor_rdata",  a_rdata,           32'h0000_0013);

        // A: request held during WAIT is not taken until the RESP cycle
        a_req = 1; a_addr = 32'h4;
        tick();
        a_addr = 32'h8;
        tick();
        chk("a_b2b_rsp1_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("a_b2b_rsp1_rdata",  a_rdata,           32'h0050_0093);
        tick();
        a_req = 0;
        chk("a_b2b_wait_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("a_b2b_wait_gnt",    {31'd0, a_gnt},    32'd0);
        tick();
        chk("a_b2b_rsp2_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("a_b2b_rsp2_rdata",  a_rdata,           32'hAAAA_0002);
        chk("a_b2b_rsp2_err",    {31'd0, a_err},    32'd0);
        tick();

        // B: zero wait states, one response per cycle
        b_req = 1; b_addr = 32'h0;
        tick();
        chk("b_s0_rvalid", {31'd0, b_rvalid}, 32'd1);
        chk("b_s0_rdata",  b_rdata,           32'h1111_1111);
        b_addr = 32'h4;
        tick();
        chk("b_s1_rvalid", {31'd0, b_rvalid}, 32'd1);
        chk("b_s1_rdata",  b_rdata,           32'h2222_2222);
        b_addr = 32'h8;
        tick();
        chk("b_s2_rvalid", {31'd0, b_rvalid}, 32'd1);
        chk("b_s2_rdata",  b_rdata,           32'h3333_3333);
        chk("b_s2_gnt",    {31'd0, b_gnt},    32'd1);

        // B: a write to the word being read on the same edge returns the old data
        b_we = 1; b_waddr = 4'd2; b_wdata = 32'h4444_4444;
        tick();
        b_we = 0;
        chk("b_raw_old", b_rdata, 32'h3333_3333);
        tick();
        chk("b_raw_new", b_rdata, 32'h4444_4444);

        // B: out of range and misaligned
        b_addr = 32'h40;
        tick();
        chk("b_oor_err",   {31'd0, b_err}, 32'd1);
        chk("b_oor_rdata", b_rdata,        32'h0000_0013);
        b_addr = 32'h6;
        tick();
        chk("b_mis_err", {31'd0, b_err}, 32'd1);
        b_req = 0;
        tick();
        chk("b_idle_rvalid", {31'd0, b_rvalid}, 32'd0);

        // C: below-base address, WAIT_STATES=2
        c_req = 1; c_addr = 32'h0FFC;
        tick();
        c_req = 0;
        tick();
        chk("c_w2_rvalid", {31'd0, c_rvalid}, 32'd0);
        chk("c_w2_gnt",    {31'd0, c_gnt},    32'd0);
        tick();
        chk("c_below_rvalid", {31'd0, c_rvalid}, 32'd1);
        chk("c_below_err",    {31'd0, c_err},    32'd1);

        // C: in-range fetch relative to the base
        c_req = 1; c_addr = 32'h1004;
        tick(); c_req = 0; tick(); tick();
        chk("c_w1_rvalid", {31'd0, c_rvalid}, 32'd1);
        chk("c_w1_rdata",  c_rdata,           32'hC1C1_C1C1);
        chk("c_w1_err",    {31'd0, c_err},    32'd0);

`ifdef INST_MEM_PERF_EN
        chk("a_req_cnt", a_rcnt, 32'd5);
        chk("a_err_cnt", a_ecnt, 32'd2);
`endif

        // C: reset during WAIT discards the request
        tick();
        c_req = 1; c_addr = 32'h1000;
        tick();
        c_req = 0;
        rst_n = 1'b0;
        #2;
        chk("c_mid_rst_rvalid", {31'd0, c_rvalid}, 32'd0);
        chk("c_mid_rst_gnt",    {31'd0, c_gnt},    32'd1);
        chk("c_mid_rst_rdata",  c_rdata,           32'h0000_0013);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("c_post_rst_rvalid", {31'd0, c_rvalid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
